// File: rtl/masked_inv_sbox_stream_if.sv
// masked_inv_sbox_stream_if: handshake bus of the masked S-box stream.
// Carries the input share pair with its fresh randomness (in_*, rnd*) and
// the output share pair (out_*). The slave modport is the S-box block; the
// master modport is whatever feeds it and drains it.
// With MASKED_SBOX_DUAL_MODE_EN defined it also carries inv_mode.
interface masked_inv_sbox_stream_if;
  logic        in_valid, in_ready;
  logic [7:0]  in0, in1;
  logic [27:0] rnd;
  logic        rnd_valid, rnd_take;
  logic        out_valid, out_ready;
  logic [7:0]  out0, out1;
`ifdef MASKED_SBOX_DUAL_MODE_EN
  logic        inv_mode;
  modport master(output in_valid, in0, in1, rnd, rnd_valid, out_ready, inv_mode,
                 input in_ready, rnd_take, out_valid, out0, out1);
  modport slave(input in_valid, in0, in1, rnd, rnd_valid, out_ready, inv_mode,
                output in_ready, rnd_take, out_valid, out0, out1);
`else
  modport master(output in_valid, in0, in1, rnd, rnd_valid, out_ready,
                 input in_ready, rnd_take, out_valid, out0, out1);
  modport slave(input in_valid, in0, in1, rnd, rnd_valid, out_ready,
                output in_ready, rnd_take, out_valid, out0, out1);
`endif
endinterface

// File: rtl/masked_inv_sbox_stream.sv
// masked_inv_sbox_stream: streaming two-share AES inverse S-box with credit-protected output FIFO.
// Ports: CLK, RST (sync, active-high); s = slave side of masked_inv_sbox_stream_if
//   (in_valid/in_ready/in0/in1, rnd/rnd_valid/rnd_take, out_valid/out_ready/out0/out1).
// Optional MASKED_SBOX_DUAL_MODE_EN adds s.inv_mode (1 = inverse, 0 = forward S-box).
// The inversion core computes x^254 share-wise with domain-oriented multiplications:
// x^3 = x*x^2, then x^15 = x^12*x^3 and x^14 = x^12*x^2 in parallel, then x^254 = x^240*x^14.
module masked_inv_sbox_stream #(
  parameter int DEPTH    = 4,
  parameter int CORE_LAT = 2
) (
  input logic CLK,
  input logic RST,
  masked_inv_sbox_stream_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(CORE_LAT + 1);
  localparam int CW = ((AW + 1) > IW ? (AW + 1) : IW) + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sq(input logic [7:0] x);
    return gmul(x, x);
  endfunction

  function automatic logic [7:0] pow4(input logic [7:0] x);
    return sq(sq(x));
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] inv_aff(input logic [7:0] x);
    return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6);
  endfunction

  logic                fire, wr, pop, inv_in;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         occ;
  logic [IW-1:0]       inflight;
  logic [CORE_LAT-1:0] vsr;
  logic [7:0]          mem0 [DEPTH];
  logic [7:0]          mem1 [DEPTH];
  logic [7:0]          c0, c1, z0, z1, f0, f1, k;
  logic [27:0]         cr;
  logic [7:0]          t00, t01, t10, t11, q0, q1;
  logic [7:0]          u00, u01, u10, u11, v00, v01, v10, v11;
  logic [7:0]          x3_0, x3_1, x12_0, x12_1, x15_0, x15_1, x14_0, x14_1, x240_0, x240_1;
  logic [15:0]         r1;
  logic [3:0]          r2a, r2b;

  assign s.in_ready = !RST && s.rnd_valid && (CW'(occ) + CW'(inflight) < CW'(DEPTH));
  assign fire       = s.in_valid && s.in_ready;
  assign s.rnd_take = fire;

  // Idle cycles feed zero shares and zero randomness so stale data never toggles the core.
  assign c0 = fire ? (inv_in ? inv_aff(s.in0) ^ 8'h05 : s.in0) : 8'h00;
  assign c1 = fire ? (inv_in ? inv_aff(s.in1) : s.in1) : 8'h00;
  assign cr = fire ? s.rnd : 28'h0;

  assign x3_0  = t00 ^ t01;
  assign x3_1  = t10 ^ t11;
  assign x12_0 = pow4(x3_0);
  assign x12_1 = pow4(x3_1);

  // Cross-domain products are masked and registered before any compression.
  always_ff @(posedge CLK) begin
    t00 <= gmul(c0, sq(c0));
    t01 <= gmul(c0, sq(c1)) ^ cr[7:0];
    t10 <= gmul(c1, sq(c0)) ^ cr[7:0];
    t11 <= gmul(c1, sq(c1));
    q0  <= sq(c0);
    q1  <= sq(c1);
    r1  <= cr[23:8];
    r2a <= cr[27:24];
    u00 <= gmul(x12_0, x3_0);
    u01 <= gmul(x12_0, x3_1) ^ r1[7:0];
    u10 <= gmul(x12_1, x3_0) ^ r1[7:0];
    u11 <= gmul(x12_1, x3_1);
    v00 <= gmul(x12_0, q0);
    v01 <= gmul(x12_0, q1) ^ r1[15:8];
    v10 <= gmul(x12_1, q0) ^ r1[15:8];
    v11 <= gmul(x12_1, q1);
    r2b <= r2a;
  end

  assign x15_0  = u00 ^ u01;
  assign x15_1  = u10 ^ u11;
  assign x14_0  = v00 ^ v01;
  assign x14_1  = v10 ^ v11;
  assign x240_0 = pow4(pow4(x15_0));
  assign x240_1 = pow4(pow4(x15_1));
  // The last multiplication spends the remaining nibble, replicated across the byte.
  assign k  = {r2b, r2b};
  assign z0 = gmul(x240_0, x14_0) ^ (gmul(x240_0, x14_1) ^ k);
  assign z1 = gmul(x240_1, x14_1) ^ (gmul(x240_1, x14_0) ^ k);

`ifdef MASKED_SBOX_DUAL_MODE_EN
  logic [CORE_LAT-1:0] msr;

  function automatic logic [7:0] fwd_aff(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4);
  endfunction

  assign inv_in = s.inv_mode;
  always_ff @(posedge CLK) msr <= RST ? '0 : (msr << 1) | CORE_LAT'(fire & inv_in);
  assign f0 = msr[CORE_LAT-1] ? z0 : fwd_aff(z0) ^ 8'h63;
  assign f1 = msr[CORE_LAT-1] ? z1 : fwd_aff(z1);
`else
  assign inv_in = 1'b1;
  assign f0     = z0;
  assign f1     = z1;
`endif

  assign wr          = vsr[CORE_LAT-1];
  assign s.out_valid = occ != '0;
  assign pop         = s.out_valid && s.out_ready;
  assign s.out0      = s.out_valid ? mem0[rd_ptr] : 8'h00;
  assign s.out1      = s.out_valid ? mem1[rd_ptr] : 8'h00;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vsr      <= '0;
      inflight <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      vsr      <= (vsr << 1) | CORE_LAT'(fire);
      inflight <= inflight + IW'(fire) - IW'(wr);
      occ      <= occ + (AW + 1)'(wr) - (AW + 1)'(pop);
      wr_ptr   <= wr_ptr + AW'(wr);
      rd_ptr   <= rd_ptr + AW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) begin
      mem0[wr_ptr] <= f0;
      mem1[wr_ptr] <= f1;
    end
  end

  overflow_chk: assert property (@(posedge CLK) disable iff (RST) !(wr && occ == (AW + 1)'(DEPTH)))
    else $error("masked_inv_sbox_stream: FIFO write while full");
endmodule
